// File: rtl/tt_um_nasser_hadi_tff_arb_if.sv
// rtl/tt_um_nasser_hadi_tff_arb_if.sv - pin bundle for the round-robin shared-toggle arbiter
//
// Purpose: groups the enable, user I/O and bidirectional-pin signals of the
// arbiter so they travel as one port. clk and rst_n stay plain ports on the
// design.
//
// Signals:
//   ena      enable; all state holds while low
//   ui_in    [3:0] request lines, [5] freeze, [7] clear, [6,4] unused
//   uio_in   unused
//   uo_out   [0] Q, [4:1] grant one-hot pulse, [7:5] toggle count mod 8
//   uio_out  [3:0] pending, [4] busy, [5] overrun, [7:6] zero
//   uio_oe   constant 8'h3F
//
// Modports: master drives the inputs (bench / surrounding logic),
//           slave is the arbiter itself.

interface tt_um_nasser_hadi_tff_arb_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/tt_um_nasser_hadi_tff_arb.sv
// rtl/tt_um_nasser_hadi_tff_arb.sv - four-requester round-robin arbiter driving a shared toggle bit
//
// Purpose: four level request lines are edge-detected into per-requester
// pending bits. Each cycle a round-robin search over the registered pending
// bits picks at most one winner; a win pulses its grant bit, toggles the
// shared bit Q, bumps a 3-bit toggle count and moves the round-robin pointer
// to the winner. A second edge arriving while a request is still pending and
// not being granted coalesces into the existing request and sets a sticky
// overrun flag.
//
// Ports:
//   clk     clock, rising edge
//   rst_n   asynchronous active-low reset
//   io_bus  slave side of tt_um_nasser_hadi_tff_arb_if
//             ena      enable (holds every register when low)
//             ui_in    [3:0] req, [5] freeze, [7] clear
//             uo_out   {count[2:0], grant[3:0], Q}
//             uio_out  {2'b00, overrun, busy, pending[3:0]}
//             uio_oe   8'h3F

module tt_um_nasser_hadi_tff_arb (
  input  logic                          clk,
  input  logic                          rst_n,
  tt_um_nasser_hadi_tff_arb_if.slave    io_bus
);

  // Registered state
  logic [3:0] r_req_prev;
  logic [3:0] r_pending;
  logic [3:0] r_grant;
  logic       r_q;
  logic [2:0] r_count;
  logic       r_overrun;
  logic [1:0] r_ptr;

  // Combinational helpers
  logic [3:0] w_req;
  logic       w_freeze;
  logic       w_clear;
  logic [3:0] w_edge;
  logic       w_win_valid;
  logic [1:0] w_winner;
  logic [1:0] w_idx;
  logic       w_fire;
  logic [3:0] w_grant_oh;
  logic [3:0] w_pending_nxt;
  logic       w_overrun_hit;
  logic       w_busy;
  logic       w_unused;

  assign w_req    = io_bus.ui_in[3:0];
  assign w_freeze = io_bus.ui_in[5];
  assign w_clear  = io_bus.ui_in[7];

  // Pins that carry no function; folded together only so they are consumed.
  assign w_unused = &{1'b0, io_bus.uio_in, io_bus.ui_in[6], io_bus.ui_in[4]};

  // Rising-edge detect against the previous enabled sample.
  assign w_edge = w_req & ~r_req_prev;

  // Round-robin search: start one past the last winner and wrap, so the
  // previous winner is considered last. r_ptr resets to 3, giving requester 0
  // first priority out of reset.
  always_comb begin
    w_win_valid = 1'b0;
    w_winner    = r_ptr;
    w_idx       = r_ptr;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_ptr + 2'(k);
      if (!w_win_valid && r_pending[w_idx]) begin
        w_win_valid = 1'b1;
        w_winner    = w_idx;
      end
    end
  end

  // Freeze suppresses the grant but not request capture.
  assign w_fire     = w_win_valid & ~w_freeze;
  assign w_grant_oh = w_fire ? (4'b0001 << w_winner) : 4'b0000;

  // The granted bit is cleared before new edges are merged in, so an edge on
  // the requester being granted this cycle re-arms it instead of being lost.
  assign w_pending_nxt = (r_pending & ~w_grant_oh) | w_edge;

  // Overrun only when an edge lands on a request that survives this cycle.
  assign w_overrun_hit = |(w_edge & r_pending & ~w_grant_oh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_prev <= 4'b0000;
      r_pending  <= 4'b0000;
      r_grant    <= 4'b0000;
      r_q        <= 1'b0;
      r_count    <= 3'd0;
      r_overrun  <= 1'b0;
      r_ptr      <= 2'd3;
    end else if (io_bus.ena) begin
      // History tracks the lines even under clear so a held line is not
      // mistaken for a fresh edge once clear drops.
      r_req_prev <= w_req;
      if (w_clear) begin
        r_pending <= 4'b0000;
        r_overrun <= 1'b0;
        r_count   <= 3'd0;
        r_grant   <= 4'b0000;
      end else begin
        r_pending <= w_pending_nxt;
        r_grant   <= w_grant_oh;
        if (w_overrun_hit) begin
          r_overrun <= 1'b1;
        end
        if (w_fire) begin
          r_q     <= ~r_q;
          r_count <= r_count + 3'd1;
          r_ptr   <= w_winner;
        end
      end
    end
  end

  assign w_busy = |r_pending;

  assign io_bus.uo_out  = {r_count, r_grant, r_q};
  assign io_bus.uio_out = {2'b00, r_overrun, w_busy, r_pending};
  assign io_bus.uio_oe  = 8'h3F;

endmodule

// File: tb/tb_tt_um_nasser_hadi_tff_arb.sv
// tb/tb_tt_um_nasser_hadi_tff_arb.sv - directed self-checking bench for the round-robin toggle arbiter

module tb_tt_um_nasser_hadi_tff_arb;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  tt_um_nasser_hadi_tff_arb_if bus ();

  tt_um_nasser_hadi_tff_arb dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges; returns on the following falling edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    bus.ena    = 1'b1;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    rst_n      = 1'b0;
    cyc(2);
    rst_n      = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.uo_out !== 8'h00) begin n_fail++; $display("FAIL reset_uo_out: got %h want 00", bus.uo_out); end
    n_cmp++; if (bus.uio_out !== 8'h00) begin n_fail++; $display("FAIL reset_uio_out: got %h want 00", bus.uio_out); end
    n_cmp++; if (bus.uio_oe !== 8'h3F) begin n_fail++; $display("FAIL reset_uio_oe: got %h want 3f", bus.uio_oe); end
  endtask

  task automatic test_single();
    do_reset();
    bus.ui_in = 8'h01;
    cyc(1);
    n_cmp++; if (bus.uio_out[3:0] !== 4'b0001) begin n_fail++; $display("FAIL single_pending1: got %b want 0001", bus.uio_out[3:0]); end
    n_cmp++; if (bus.uo_out[4:1] !== 4'b0000) begin n_fail++; $display("FAIL single_grant1: got %b want 0000", bus.uo_out[4:1]); end
    cyc(1);
    n_cmp++; if (bus.uo_out !== {3'd1, 4'b0001, 1'b1}) begin n_fail++; $display("FAIL single_grant2: got %h want %h", bus.uo_out, {3'd1, 4'b0001, 1'b1}); end
    cyc(1);
    n_cmp++; if (bus.uo_out[4:1] !== 4'b0000) begin n_fail++; $display("FAIL single_grant3: got %b want 0000", bus.uo_out[4:1]); end
    n_cmp++; if (bus.uio_out[4:0] !== 5'b00000) begin n_fail++; $display("FAIL single_pending3: got %b want 00000", bus.uio_out[4:0]); end
    bus.ui_in = 8'h00;
  endtask

  task automatic test_all_four();
    logic [3:0] eg [0:3];
    logic [3:0] ep [0:3];
    eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    ep = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
    do_reset();
    bus.ui_in = 8'h0F;
    cyc(1);
    bus.ui_in = 8'h00;
    n_cmp++; if (bus.uio_out[4:0] !== 5'b11111) begin n_fail++; $display("FAIL all4_pending: got %b want 11111", bus.uio_out[4:0]); end
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      n_cmp++; if (bus.uo_out[4:1] !== eg[i]) begin n_fail++; $display("FAIL all4_grant[%0d]: got %b want %b", i, bus.uo_out[4:1], eg[i]); end
      n_cmp++; if (bus.uio_out[3:0] !== ep[i]) begin n_fail++; $display("FAIL all4_pend[%0d]: got %b want %b", i, bus.uio_out[3:0], ep[i]); end
      n_cmp++; if (bus.uo_out[0] !== ~i[0]) begin n_fail++; $display("FAIL all4_q[%0d]: got %b want %b", i, bus.uo_out[0], ~i[0]); end
    end
    n_cmp++; if (bus.uo_out[7:5] !== 3'd4) begin n_fail++; $display("FAIL all4_count: got %0d want 4", bus.uo_out[7:5]); end
    n_cmp++; if (bus.uio_out[4] !== 1'b0) begin n_fail++; $display("FAIL all4_busy: got %b want 0", bus.uio_out[4]); end
  endtask

  task automatic test_fairness();
    do_reset();
    // One grant to req0 leaves ptr=0.
    bus.ui_in = 8'h01;
    cyc(1);
    bus.ui_in = 8'h00;
    cyc(1);
    n_cmp++; if (bus.uo_out[4:1] !== 4'b0001) begin n_fail++; $display("FAIL fair_setup: got %b want 0001", bus.uo_out[4:1]); end
    bus.ui_in = 8'h05;
    cyc(1);
    for (int i = 0; i < 3; i++) begin
      bus.ui_in = 8'h00;
      cyc(1);
      n_cmp++; if (bus.uo_out[4:1] !== 4'b0100) begin n_fail++; $display("FAIL fair_g2[%0d]: got %b want 0100", i, bus.uo_out[4:1]); end
      bus.ui_in = 8'h05;
      cyc(1);
      n_cmp++; if (bus.uo_out[4:1] !== 4'b0001) begin n_fail++; $display("FAIL fair_g0[%0d]: got %b want 0001", i, bus.uo_out[4:1]); end
    end
    n_cmp++; if (bus.uo_out[7:5] !== 3'd7) begin n_fail++; $display("FAIL fair_count: got %0d want 7", bus.uo_out[7:5]); end
    n_cmp++; if (bus.uio_out[5] !== 1'b0) begin n_fail++; $display("FAIL fair_overrun: got %b want 0", bus.uio_out[5]); end
    bus.ui_in = 8'h00;
  endtask

  task automatic test_overrun();
    do_reset();
    bus.ui_in = 8'h22;
    cyc(1);
    bus.ui_in = 8'h20;
    cyc(1);
    bus.ui_in = 8'h22;
    cyc(1);
    n_cmp++; if (bus.uio_out !== 8'h32) begin n_fail++; $display("FAIL ovr_frozen: got %h want 32", bus.uio_out); end
    n_cmp++; if (bus.uo_out !== 8'h00) begin n_fail++; $display("FAIL ovr_frozen_uo: got %h want 00", bus.uo_out); end
    bus.ui_in = 8'h00;
    cyc(1);
    n_cmp++; if (bus.uo_out !== {3'd1, 4'b0010, 1'b1}) begin n_fail++; $display("FAIL ovr_grant: got %h want %h", bus.uo_out, {3'd1, 4'b0010, 1'b1}); end
    cyc(1);
    n_cmp++; if (bus.uo_out[4:1] !== 4'b0000) begin n_fail++; $display("FAIL ovr_once: got %b want 0000", bus.uo_out[4:1]); end
    n_cmp++; if (bus.uio_out !== 8'h20) begin n_fail++; $display("FAIL ovr_sticky: got %h want 20", bus.uio_out); end
    // Clear with req0 rising: history updates, nothing is captured.
    bus.ui_in = 8'h81;
    cyc(1);
    n_cmp++; if (bus.uio_out !== 8'h00) begin n_fail++; $display("FAIL clr_uio: got %h want 00", bus.uio_out); end
    n_cmp++; if (bus.uo_out !== 8'h01) begin n_fail++; $display("FAIL clr_uo: got %h want 01", bus.uo_out); end
    bus.ui_in = 8'h01;
    cyc(1);
    n_cmp++; if (bus.uio_out[3:0] !== 4'b0000) begin n_fail++; $display("FAIL clr_history: got %b want 0000", bus.uio_out[3:0]); end
    bus.ui_in = 8'h00;
  endtask

  task automatic test_simul();
    do_reset();
    bus.ui_in = 8'h22;
    cyc(1);
    bus.ui_in = 8'h20;
    cyc(1);
    bus.ui_in = 8'h02;
    cyc(1);
    n_cmp++; if (bus.uo_out[4:1] !== 4'b0010) begin n_fail++; $display("FAIL simul_grant1: got %b want 0010", bus.uo_out[4:1]); end
    n_cmp++; if (bus.uio_out !== 8'h12) begin n_fail++; $display("FAIL simul_pending: got %h want 12", bus.uio_out); end
    cyc(1);
    n_cmp++; if (bus.uo_out !== {3'd2, 4'b0010, 1'b0}) begin n_fail++; $display("FAIL simul_grant2: got %h want %h", bus.uo_out, {3'd2, 4'b0010, 1'b0}); end
    n_cmp++; if (bus.uio_out !== 8'h00) begin n_fail++; $display("FAIL simul_after: got %h want 00", bus.uio_out); end
    bus.ui_in = 8'h00;
  endtask

  task automatic test_ena_hold();
    logic [7:0] pat [0:4];
    pat = '{8'h0F, 8'h00, 8'h0E, 8'h00, 8'h0F};
    do_reset();
    bus.ui_in = 8'h01;
    cyc(1);
    bus.ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.ui_in = pat[i];
      cyc(1);
      n_cmp++; if ({bus.uo_out, bus.uio_out} !== 16'h0011) begin n_fail++; $display("FAIL ena_hold[%0d]: got %h want 0011", i, {bus.uo_out, bus.uio_out}); end
    end
    bus.ui_in = 8'h01;
    bus.ena   = 1'b1;
    cyc(1);
    n_cmp++; if (bus.uo_out !== {3'd1, 4'b0001, 1'b1}) begin n_fail++; $display("FAIL ena_resume: got %h want %h", bus.uo_out, {3'd1, 4'b0001, 1'b1}); end
    cyc(1);
    n_cmp++; if (bus.uio_out !== 8'h00) begin n_fail++; $display("FAIL ena_history: got %h want 00", bus.uio_out); end
    bus.ui_in = 8'h00;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      bus.ui_in = 8'h01;
      cyc(1);
      bus.ui_in = 8'h00;
      cyc(1);
      if (i == 8) begin
        n_cmp++; if (bus.uo_out[7:5] !== 3'd0) begin n_fail++; $display("FAIL wrap_count8: got %0d want 0", bus.uo_out[7:5]); end
      end
    end
    n_cmp++; if (bus.uo_out !== {3'd1, 4'b0001, 1'b1}) begin n_fail++; $display("FAIL wrap_count9: got %h want %h", bus.uo_out, {3'd1, 4'b0001, 1'b1}); end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.ui_in = 8'h0F;
    cyc(2);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.uo_out, bus.uio_out} !== 16'h0000) begin n_fail++; $display("FAIL async_rst: got %h want 0000", {bus.uo_out, bus.uio_out}); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    n_cmp++; if (bus.uio_out[4:0] !== 5'b11111) begin n_fail++; $display("FAIL rst_held_edge: got %b want 11111", bus.uio_out[4:0]); end
    bus.ui_in = 8'h00;
    cyc(1);
    n_cmp++; if (bus.uo_out[4:1] !== 4'b0001) begin n_fail++; $display("FAIL rst_first_prio: got %b want 0001", bus.uo_out[4:1]); end
  endtask

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    bus.ena    = 1'b1;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    @(negedge clk);
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_overrun();
    test_simul();
    test_ena_hold();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_um_nasser_hadi_tff_arb.md
TT_UM_NASSER_HADI_TFF_ARB -- requirements
Module: tt_um_nasser_hadi_tff_arb

Interface
REQ-001 The block SHALL have no parameters; requester count is fixed at 4.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ena  input  1  enable; when 0, all state SHALL hold, including the edge-detect history.
REQ-005 ui_in  input  8  [3:0] toggle request lines req[3:0] (level, edge-detected); [5] freeze; [7] clear; [6,4] unused.
REQ-006 uo_out  output  8  [0] Q (shared toggle bit); [4:1] grant[3:0] one-hot pulse; [7:5] toggle count mod 8.
REQ-007 uio_in  input  8  unused.
REQ-008 uio_out  output  8  [3:0] pending[3:0]; [4] busy (OR of pending); [5] overrun (sticky); [7:6] constant 0.
REQ-009 uio_oe  output  8  SHALL be constant 8'h3F.

Function
REQ-010 Every edge below SHALL be qualified by ena=1; with ena=0 no register changes.
REQ-011 Register req_prev[3:0] SHALL sample ui_in[3:0] every enabled edge; edge[i] = ui_in[i] & ~req_prev[i].
REQ-012 Each requester SHALL own one pending bit, set by edge[i] at the same clock edge on which the edge is detected.
REQ-013 Arbitration SHALL be round-robin over the registered pending bits: search order starts at (ptr+1) mod 4 and wraps; the first set bit wins.
REQ-014 On a win at edge N, the block SHALL register grant = one-hot(winner), toggle Q, increment count mod 8 (7 wraps to 0), set ptr = winner, and clear pending[winner].
REQ-015 With no pending bits, or with freeze=1, the block SHALL register grant = 0 and leave Q, count and ptr unchanged; pending bits still accumulate under freeze.
REQ-016 Grant SHALL be a single-cycle pulse; at most one grant bit is set per cycle.
REQ-017 Q SHALL toggle exactly once per grant.
REQ-018 Latency: a rising request sampled at edge N sets pending after N; the earliest grant and Q toggle are visible after edge N+1.
REQ-019 Simultaneous grant and new edge on the same requester: pending[i] SHALL remain 1, so the new request is retained and no overrun occurs.
REQ-020 New edge while pending[i]=1 and i is not granted that cycle: the edges SHALL coalesce into one pending request, and overrun SHALL be set to 1.
REQ-021 Overrun SHALL stay 1 until clear or reset.
REQ-022 Clear (ui_in[7]=1) SHALL take priority over all other actions and set pending=0, overrun=0, count=0, grant=0.
REQ-023 Under clear, Q and ptr SHALL hold, req_prev still updates, and no toggle occurs that cycle.
REQ-024 busy SHALL be combinational OR of the registered pending bits; all other outputs SHALL be driven directly from registers.

Reset
REQ-025 While rst_n=0, the block SHALL immediately force Q=0, grant=0, count=0, pending=0, overrun=0, req_prev=0 and ptr=3, so requester 0 has first priority.
REQ-026 Reset asserted mid-operation SHALL discard all pending requests.
REQ-027 After rst_n deasserts, a request line already high SHALL register as an edge at the first enabled clock edge.

Verification
REQ-028 Single request: raise req0 at cycle 1 -> pending=0001 after cycle 1; grant=0001, Q=1, count=1 after cycle 2; pending=0000 and grant=0000 after cycle 3.
REQ-029 All four requests rise at once from reset -> grants follow 0001,0010,0100,1000 on consecutive cycles; Q toggles 4 times ending at 0; count=4; busy deasserts after the last grant.
REQ-030 Fairness: keep re-pulsing req0 and req2 every 2 cycles with ptr=0 -> grants alternate 0100,0001,... and no requester is granted twice while the other is pending.
REQ-031 Overrun: freeze=1, pulse req1 twice -> pending=0010 and overrun=1; release freeze -> exactly one grant 0010; overrun stays 1 until clear=1, which zeroes count, pending and overrun with Q unchanged.
REQ-032 Simultaneous grant and edge: pending1=1 and req1 rises on the granting cycle -> pending1 stays 1, a second grant 0010 follows, and overrun stays 0.
REQ-033 ena=0 for 5 cycles with requests toggling -> no output changes; 9 grants -> count wraps to 1; rst_n low mid-burst -> all outputs 0 asynchronously.
